inv_round_ctrl: RTL and testbench
=================================

Name: inv_round_ctrl

Overview:
Sequencer for the combinational reverseround datapath (one AES inverse round per use). It accepts a 128-bit ciphertext and applies the initial AddRoundKey. It then runs the reverseround instance NR times, feeding state and the matching round key each cycle, and presents the plaintext on a valid/ready output handshake. Round keys come from an external key-schedule store, addressed by key_idx.

Parameters:
NR, 10, number of inverse rounds; legal values 10/12/14 (AES-128/192/256).
W, 128, state and round-key width in bits; fixed at 128, present for port sizing only.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset
start  input  1  request to decrypt cipher_in; accepted only when ready=1
ready  output  1  controller idle and able to accept start
abort  input  1  synchronous cancel of the current operation
cipher_in  input  W  ciphertext; sampled on the accept cycle only
key_idx  output  4  round-key index presented to the key store
rkey  input  W  round key for key_idx; combinational, valid in the same cycle
rr_in  output  W  state driven to the reverseround roundin
rr_key  output  W  key driven to the reverseround key input; equals rkey
rr_last  output  1  final-round flag; the datapath skips InvMixColumns when it is 1
rr_out  input  W  reverseround roundout
plain_out  output  W  result; meaningful only while out_valid=1
out_valid  output  1  result available
out_ready  input  1  consumer accepts the result
round_cnt  output  4  current round index, for debug

Behaviour:
- FSM states: IDLE, ROUND, DONE. Registers: state[W-1:0], rnd[3:0].
- Reset (rst=0, asynchronous):
  - FSM=IDLE, state=0, rnd=0.
  - ready=1, out_valid=0, plain_out=0.
  - key_idx=NR, rr_last=0, round_cnt=0.
- IDLE:
  - Outputs: ready=1, key_idx=NR, rr_last=0.
  - start=1 and abort=0: state<=cipher_in^rkey (rkey is round key NR), rnd<=NR-1, go to ROUND.
- ROUND:
  - Outputs: ready=0, key_idx=rnd, rr_in=state, rr_key=rkey, rr_last=(rnd==0), round_cnt=rnd.
  - Every cycle: state<=rr_out.
  - rnd!=0: rnd<=rnd-1 and stay in ROUND.
  - rnd==0: go to DONE.
  - ROUND lasts exactly NR cycles.
- DONE:
  - Outputs: out_valid=1, plain_out=state, ready=0.
  - state holds until out_valid&&out_ready, then go to IDLE.
  - out_valid may stay high indefinitely; plain_out must stay stable while out_valid=1 and out_ready=0.
- Latency:
  - Accept on cycle 0.
  - out_valid=1 on cycle NR+1 (cycle 11 for NR=10).
  - ready returns on the cycle after the output handshake.
  - Minimum issue interval is NR+2 cycles.
- rr_in is driven from state in all states. key_idx is NR in IDLE and DONE.
- abort:
  - abort=1 in any state: go to IDLE next cycle; out_valid deasserts and no result is emitted.
  - state is not cleared.
  - abort and start together in IDLE: abort wins and start is ignored.
- start while ready=0 is ignored and not queued. cipher_in is not re-sampled after the accept cycle.
- out_ready while out_valid=0 has no effect.
- rst asserted mid-ROUND or mid-DONE: immediate return to reset values; the partial result is discarded.
- Widths: all XOR operations are W bits. rnd never underflows because the exit is taken at rnd==0.

Test Plan:
- Reset check: assert rst=0 mid-ROUND -> ready=1, out_valid=0, key_idx=NR, plain_out=0 immediately, with no clock edge required.
- Stub sequencing (NR=10), with stub rr_out=rr_in^rr_key and stub key store rkey={16{key_idx[7:0] as byte}}:
  - Stimulus: cipher_in=0, start pulse.
  - key_idx sequence over cycles 0..10: 10, 9, 8, …, 0.
  - rr_last=1 only on cycle 10.
  - out_valid rises at cycle 11 with plain_out={16{8'h0b}}.
- Real datapath (NR=10), with reverseround and an AES-128 key schedule for key 000102030405060708090a0b0c0d0e0f:
  - Stimulus: cipher_in=69c4e0d86a7b0430d8cdb78070b4c55a.
  - Required: plain_out=00112233445566778899aabbccddeeff.
- Backpressure:
  - Hold out_ready=0 for 5 cycles after out_valid -> out_valid and plain_out stay stable and ready=0.
  - Pulse out_ready=1 -> ready=1 the next cycle.
  - start pulses during ROUND or DONE are ignored: no second result appears.
- Abort:
  - abort=1 at cycle 4 of ROUND -> IDLE at cycle 5, out_valid never rises.
  - A subsequent start with the stub vector still yields {16{8'h0b}}.
- Back-to-back:
  - Two starts issued as soon as ready=1, with out_ready tied to 1.
  - Required: results at cycles 11 and 23, both correct, and ready low for exactly 11 cycles each time.

Source files
------------

// File: rtl/inv_round_ctrl.sv
// rtl/inv_round_ctrl.sv - sequencer for one-round-per-cycle AES inverse cipher
// Drives an external combinational reverseround datapath NR times per block.
module inv_round_ctrl #(
  parameter int NR = 10,
  parameter int W  = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         ready,
  input  logic         abort,
  input  logic [W-1:0] cipher_in,
  output logic [3:0]   key_idx,
  input  logic [W-1:0] rkey,
  output logic [W-1:0] rr_in,
  output logic [W-1:0] rr_key,
  output logic         rr_last,
  input  logic [W-1:0] rr_out,
  output logic [W-1:0] plain_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [3:0]   round_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } fsm_t;

  localparam logic [3:0] NR_IDX  = 4'(NR);
  localparam logic [3:0] NR_LAST = 4'(NR - 1);

  fsm_t         fsm, fsm_nxt;
  logic [W-1:0] state, state_nxt;
  logic [3:0]   rnd, rnd_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm   <= IDLE;
      state <= '0;
      rnd   <= '0;
    end else begin
      fsm   <= fsm_nxt;
      state <= state_nxt;
      rnd   <= rnd_nxt;
    end
  end

  always_comb begin
    fsm_nxt   = fsm;
    state_nxt = state;
    rnd_nxt   = rnd;
    ready     = 1'b0;
    out_valid = 1'b0;
    key_idx   = NR_IDX;
    rr_last   = 1'b0;

    case (fsm)
      IDLE: begin
        ready = 1'b1;
        // key store is addressed at NR here, so rkey is the initial AddRoundKey
        if (start && !abort) begin
          state_nxt = cipher_in ^ rkey;
          rnd_nxt   = NR_LAST;
          fsm_nxt   = ROUND;
        end
      end
      ROUND: begin
        key_idx   = rnd;
        rr_last   = (rnd == 4'd0);
        state_nxt = rr_out;
        if (rnd == 4'd0) begin
          fsm_nxt = DONE;
        end else begin
          rnd_nxt = rnd - 4'd1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          fsm_nxt = IDLE;
        end
      end
      default: begin
        fsm_nxt = IDLE;
      end
    endcase

    // cancel leaves the working state untouched and just parks the FSM
    if (abort) begin
      fsm_nxt   = IDLE;
      state_nxt = state;
      rnd_nxt   = rnd;
    end
  end

  assign rr_in     = state;
  assign rr_key    = rkey;
  assign plain_out = out_valid ? state : '0;
  assign round_cnt = rnd;

endmodule

// File: tb/tb_inv_round_ctrl.sv
// tb/tb_inv_round_ctrl.sv - self-checking bench for inv_round_ctrl
// Uses a stub round datapath and key store; results come from a block-level model.
module tb_inv_round_ctrl;

  localparam int NR = 10;
  localparam int W  = 128;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         out_ready = 1'b0;
  logic         mode = 1'b0;
  logic [W-1:0] cipher_in = '0;
  logic         ready, rr_last, out_valid;
  logic [3:0]   key_idx, round_cnt;
  logic [W-1:0] rkey, rr_in, rr_key, rr_out, plain_out;
  logic [W-1:0] keys [16];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [W-1:0] rr_f(input logic [W-1:0] s, input logic [W-1:0] k,
                                        input logic last, input logic m);
    logic [W-1:0] x;
    x = s ^ k;
    if (m && !last) x = {x[W-2:0], x[W-1]};
    return x;
  endfunction

  assign rkey   = keys[key_idx];
  assign rr_out = rr_f(rr_in, rr_key, rr_last, mode);

  inv_round_ctrl #(.NR(NR), .W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .ready(ready), .abort(abort),
    .cipher_in(cipher_in), .key_idx(key_idx), .rkey(rkey), .rr_in(rr_in),
    .rr_key(rr_key), .rr_last(rr_last), .rr_out(rr_out), .plain_out(plain_out),
    .out_valid(out_valid), .out_ready(out_ready), .round_cnt(round_cnt)
  );

  // Block-level reference: initial key add with key NR, then rounds NR-1 down to 0.
  function automatic logic [W-1:0] ref_decrypt(input logic [W-1:0] c);
    logic [W-1:0] s;
    s = c ^ keys[NR];
    for (int r = NR - 1; r >= 0; r--) s = rr_f(s, keys[r], r == 0, mode);
    return s;
  endfunction

  function automatic logic [W-1:0] rand_w();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction; the caller guarantees ready=1 on entry.
  task automatic run_op(input logic [W-1:0] c, input int hold, input bit noisy,
                        input logic [W-1:0] exp);
    cipher_in = c;
    start     = 1'b1;
    chk("accept_ready", W'(ready), W'(1));
    chk("accept_key_idx", W'(key_idx), W'(NR));
    for (int k = 1; k <= NR; k++) begin
      tick();
      start     = noisy && (k == 3);
      cipher_in = noisy ? rand_w() : c;
      chk("round_key_idx", W'(key_idx), W'(NR - k));
      chk("round_cnt", W'(round_cnt), W'(NR - k));
      chk("round_last", W'(rr_last), W'(k == NR));
      chk("round_busy", W'({ready, out_valid}), W'(0));
    end
    tick();
    start = 1'b0;
    chk("done_valid", W'({out_valid, ready}), W'(2'b10));
    chk("done_plain", plain_out, exp);
    chk("done_key_idx", W'(key_idx), W'(NR));
    for (int h = 0; h < hold; h++) begin
      start = noisy;
      tick();
      chk("hold_valid", W'({out_valid, ready}), W'(2'b10));
      chk("hold_plain", plain_out, exp);
    end
    start     = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("post_handshake", W'({ready, out_valid}), W'(2'b10));
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk("no_extra_result", W'({out_valid, ready}), W'(2'b01));
    end
  endtask

  logic [W-1:0] c0, c1, e0, e1;
  logic [W-1:0] res_val [2];
  int           res_cyc [2];
  int           n_res, issued, low;

  initial begin
    for (int i = 0; i < 16; i++) keys[i] = {16{8'(i)}};

    // reset state, no clock edge yet
    #2;
    chk("rst_ready", W'(ready), W'(1));
    chk("rst_valid", W'(out_valid), W'(0));
    chk("rst_key_idx", W'(key_idx), W'(NR));
    chk("rst_plain", plain_out, '0);
    chk("rst_round_cnt", W'(round_cnt), W'(0));
    chk("rst_last", W'(rr_last), W'(0));
    #1 rst = 1'b1;
    tick();

    // stub sequencing with byte-pattern keys, including backpressure
    chk("stub_model", ref_decrypt('0), {16{8'h0b}});
    run_op('0, 5, 1'b1, {16{8'h0b}});
    quiet(4);

    // asynchronous reset in the middle of ROUND
    cipher_in = rand_w();
    start     = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    #1 rst = 1'b0;
    #1;
    chk("midrst_ready", W'(ready), W'(1));
    chk("midrst_valid", W'(out_valid), W'(0));
    chk("midrst_key_idx", W'(key_idx), W'(NR));
    chk("midrst_plain", plain_out, '0);
    chk("midrst_round_cnt", W'(round_cnt), W'(0));
    rst = 1'b1;
    tick();

    // abort on cycle 4 of the operation
    cipher_in = '0;
    start     = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      start = 1'b0;
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_idle", W'(ready), W'(1));
    chk("abort_key_idx", W'(key_idx), W'(NR));
    quiet(14);

    // abort and start together in IDLE: abort wins
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    chk("abort_start_idle", W'({ready, out_valid}), W'(2'b10));
    quiet(12);

    // abort while the result is waiting in DONE
    start = 1'b1;
    for (int k = 1; k <= NR + 1; k++) begin
      tick();
      start = 1'b0;
    end
    chk("abort_done_valid", W'(out_valid), W'(1));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_done_idle", W'({ready, out_valid}), W'(2'b10));
    quiet(3);

    // stub vector still correct after aborts
    run_op('0, 0, 1'b0, {16{8'h0b}});

    // randomized keys, ciphertexts and backpressure with rr_last-sensitive stub
    mode = 1'b1;
    for (int i = 0; i < 16; i++) keys[i] = rand_w();
    for (int t = 0; t < 8; t++) begin
      c0 = rand_w();
      e0 = ref_decrypt(c0);
      run_op(c0, $urandom_range(0, 4), t[0], e0);
      if ($urandom_range(0, 1) == 1) tick();
    end

    // back-to-back with out_ready held high
    c0 = rand_w();
    c1 = rand_w();
    e0 = ref_decrypt(c0);
    e1 = ref_decrypt(c1);
    n_res     = 0;
    issued    = 1;
    low       = 0;
    out_ready = 1'b1;
    cipher_in = c0;
    start     = 1'b1;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      tick();
      start = 1'b0;
      if (out_valid && n_res < 2) begin
        res_cyc[n_res] = cyc;
        res_val[n_res] = plain_out;
        n_res++;
      end
      if (!ready) low++;
      if (ready && issued < 2) begin
        cipher_in = c1;
        start     = 1'b1;
        issued++;
      end
    end
    out_ready = 1'b0;
    chk("b2b_count", W'(n_res), W'(2));
    if (n_res == 2) begin
      chk("b2b_cyc0", W'(res_cyc[0]), W'(NR + 1));
      chk("b2b_cyc1", W'(res_cyc[1]), W'(2 * NR + 3));
      chk("b2b_val0", res_val[0], e0);
      chk("b2b_val1", res_val[1], e1);
    end
    chk("b2b_ready_low", W'(low), W'(2 * (NR + 1)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
